spi_config_master: RTL and testbench
====================================

Name: spi_config_master

Overview:
- SPI mode-0 initiator that drives the chip's SPI configuration port (SCLK/MOSI/SS/MISO) from an on-board or FPGA-side test harness.
- Issues one frame per start request: instruction byte, address MSB, address LSB, then 0..255 data bytes, all MSB first.
- Returns each MISO byte captured during the data phase, so configuration memory can be written and read back.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 8, idle clk cycles between bytes; used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; accepted only when busy=0
- instr  input  8  instruction byte, sent first
- addr  input  16  address; [15:8] sent second, [7:0] sent third
- len  input  8  number of data bytes after the header; 0 = header-only frame
- wr_data  input  8  data byte to transmit; must be valid in the cycle wr_data_req=1
- wr_data_req  output  1  one-cycle pop strobe for the next data byte
- rd_data  output  8  byte captured on MISO during the last data byte
- rd_valid  output  1  one-cycle strobe; rd_data is valid
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- done  output  1  one-cycle pulse in the cycle ss deasserts
- sclk  output  1  SPI clock; idles low
- mosi  output  1  SPI data out
- ss  output  1  slave select; active low
- miso  input  1  SPI data in

Behaviour:
- Reset (asynchronous, immediate): ss=1, sclk=0, mosi=0, busy=0, done=0, rd_valid=0, wr_data_req=0, rd_data=0; FSM returns to IDLE. Reset mid-frame aborts the frame with no done pulse.
- Start acceptance: on start while IDLE, latch instr, addr and len; total bytes = 3+len (9-bit arithmetic, no overflow). start while busy is ignored.
- States and transitions:
  - IDLE -> SETUP on accepted start. In SETUP, ss=0 and mosi=instr[7].
  - SETUP lasts CLK_DIV cycles, then -> SHIFT.
  - SHIFT: sclk toggles every CLK_DIV clk cycles; 16 half-periods per byte.
    - Rising sclk: sample miso into the shift register.
    - Falling sclk: present the next bit on mosi.
  - After the 8th rising edge and the following falling edge: if bytes remain, load the next byte and stay in SHIFT; otherwise -> HOLD.
  - HOLD: ss stays 0 and sclk stays 0 for CLK_DIV cycles, then ss=1 and done=1 -> DESEL.
  - DESEL: ss=1 for CLK_DIV cycles, then -> IDLE and busy=0.
- Data bytes:
  - wr_data_req pulses one clk before the first bit of each data byte drives mosi; wr_data is sampled in that same cycle.
  - No wr_data_req for the header bytes.
- Read-back: rd_valid pulses in the cycle after the 8th rising sclk of each data byte; rd_data holds the byte until the next capture. No rd_valid for header bytes.
- mosi after the last bit: holds the last bit until ss rises, then 0.
- Frame length, gap disabled: (3+len)*16*CLK_DIV + 3*CLK_DIV clk cycles from start to IDLE. len=0 gives exactly 3 bytes and zero strobes.

Optional Feature:
- Macro: SPI_CONFIG_MASTER_BYTE_GAP_EN.
- When defined: after each byte except the last, insert GAP_CYCLES clk cycles with sclk=0 and ss=0 (state GAP) before the next byte's first bit. wr_data_req moves to the last GAP cycle.
- When undefined: bytes are back-to-back, GAP state and GAP_CYCLES are unused, timing as above.

Test Plan:
- Write frame: CLK_DIV=2, instr=0x01, addr=0x0003, len=1, wr_data=0x5A.
  - MOSI decodes 01 00 03 5A.
  - One wr_data_req; done at cycle 4*32+4; busy low 2 cycles later.
- Read-back: len=2 with a slave model returning 0xC3 then 0x3C.
  - rd_valid twice, with rd_data 0xC3 then 0x3C.
  - Header MISO bits produce no rd_valid.
- Header-only: len=0, instr=0xA5, addr=0x1234.
  - MOSI decodes A5 12 34.
  - Zero wr_data_req and zero rd_valid; exactly 24 rising sclk edges.
- start while busy: second start pulse mid-frame with different instr is ignored; the frame completes unchanged.
- Reset mid-frame: reset_n low during byte 2.
  - ss=1, sclk=0, busy=0 immediately; no done pulse.
  - A new start after release gives a clean frame.
- Minimum divider: CLK_DIV=1, len=255.
  - 258 bytes decode correctly, 255 wr_data_req and 255 rd_valid; with the gap macro, a GAP_CYCLES idle between every byte.

Source files
------------

// File: rtl/spi_config_master.sv
// SPI mode-0 configuration-port initiator: instr, addr[15:8], addr[7:0], then len data bytes, MSB first.
// Optional inter-byte idle gap enabled by defining SPI_CONFIG_MASTER_BYTE_GAP_EN.
module spi_config_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  instr,
  input  logic [15:0] addr,
  input  logic [7:0]  len,
  input  logic [7:0]  wr_data,
  output logic        wr_data_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  input  logic        miso
);

  if (CLK_DIV < 1 || CLK_DIV > 255 || GAP_CYCLES < 1) begin : g_bad_param
    $error("spi_config_master: CLK_DIV must be 1..255 and GAP_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DESEL, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_PRE  = 8'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  hp;        // half-period index within a byte; even = sclk high
  logic [8:0]  byte_idx;  // index of the byte currently in tx
  logic [8:0]  total;
  logic [15:0] addr_q;
  logic [7:0]  tx, rx;
  logic        loaded;    // next byte already in tx, rise at end of hp15
  logic        cap_pend;

  logic        tick, more, nxt_data, req_pre;
  logic [8:0]  nxt_idx;
  logic [7:0]  nb;

  assign tick     = (div_cnt == DIV_LAST);
  assign nxt_idx  = byte_idx + 9'd1;
  assign more     = (nxt_idx < total);
  assign nxt_data = (nxt_idx >= 9'd3);
  assign nb       = (nxt_idx == 9'd1) ? addr_q[15:8] :
                    (nxt_idx == 9'd2) ? addr_q[7:0]  : wr_data;

`ifdef SPI_CONFIG_MASTER_BYTE_GAP_EN
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] GAP_PRE  = 16'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  logic [15:0] gap_cnt;

  // request lands in the final GAP cycle; byte is loaded on GAP exit
  assign req_pre = more && nxt_data &&
                   ((GAP_CYCLES == 1) ? (state == SHIFT && hp == 4'd15 && tick && !loaded)
                                      : (state == GAP && gap_cnt == GAP_PRE));
`else
  // request lands in the cycle before the fall into hp15, where the next byte loads
  assign req_pre = (state == SHIFT) && more && nxt_data &&
                   ((CLK_DIV == 1) ? (hp == 4'd13) : (hp == 4'd14 && div_cnt == DIV_PRE));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hp          <= '0;
      byte_idx    <= '0;
      total       <= '0;
      addr_q      <= '0;
      tx          <= '0;
      rx          <= '0;
      loaded      <= 1'b0;
      cap_pend    <= 1'b0;
      wr_data_req <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      ss          <= 1'b1;
`ifdef SPI_CONFIG_MASTER_BYTE_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      cap_pend    <= 1'b0;
      wr_data_req <= req_pre;
      if (cap_pend) begin
        rd_data  <= rx;
        rd_valid <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state    <= SETUP;
          busy     <= 1'b1;
          ss       <= 1'b0;
          mosi     <= instr[7];
          tx       <= instr;
          addr_q   <= addr;
          total    <= 9'd3 + {1'b0, len};
          byte_idx <= '0;
          div_cnt  <= '0;
          hp       <= '0;
          loaded   <= 1'b0;
        end
        SETUP: if (tick) begin
          div_cnt <= '0;
          hp      <= '0;
          sclk    <= 1'b1;
          rx      <= {rx[6:0], miso};
          state   <= SHIFT;
        end else div_cnt <= div_cnt + 8'd1;
        SHIFT: if (!tick) div_cnt <= div_cnt + 8'd1;
        else begin
          div_cnt <= '0;
          if (hp == 4'd15) begin
            if (loaded) begin
              loaded <= 1'b0;
              hp     <= '0;
              sclk   <= 1'b1;
              rx     <= {rx[6:0], miso};
            end else begin
`ifdef SPI_CONFIG_MASTER_BYTE_GAP_EN
              if (more) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else state <= HOLD;
`else
              state <= HOLD;
`endif
            end
          end else begin
            hp <= hp + 4'd1;
            if (!hp[0]) begin
              sclk <= 1'b0;
              if (hp != 4'd14) begin
                tx   <= {tx[6:0], 1'b0};
                mosi <= tx[6];
              end
`ifndef SPI_CONFIG_MASTER_BYTE_GAP_EN
              else if (more) begin
                tx       <= nb;
                mosi     <= nb[7];
                byte_idx <= nxt_idx;
                loaded   <= 1'b1;
              end
`endif
            end else begin
              sclk <= 1'b1;
              rx   <= {rx[6:0], miso};
              if (hp == 4'd13 && byte_idx >= 9'd3) cap_pend <= 1'b1;
            end
          end
        end
        HOLD: if (tick) begin
          div_cnt <= '0;
          ss      <= 1'b1;
          done    <= 1'b1;
          mosi    <= 1'b0;
          state   <= DESEL;
        end else div_cnt <= div_cnt + 8'd1;
        DESEL: if (tick) begin
          div_cnt <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end else div_cnt <= div_cnt + 8'd1;
`ifdef SPI_CONFIG_MASTER_BYTE_GAP_EN
        GAP: if (gap_cnt == GAP_LAST) begin
          // re-enter on a low half-period so mosi settles before the next rise
          tx       <= nb;
          mosi     <= nb[7];
          byte_idx <= nxt_idx;
          loaded   <= 1'b1;
          hp       <= 4'd15;
          div_cnt  <= '0;
          state    <= SHIFT;
        end else gap_cnt <= gap_cnt + 16'd1;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: two instances (CLK_DIV=2 and CLK_DIV=1) behind a mux, SPI slave model + scoreboard.
module tb_spi_config_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  instr = '0, len = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wr_data = '0;
  logic        miso = 1'b0;

  logic [1:0] start_i, wreq_i, rdv_i, busy_i, done_i, sclk_i, mosi_i, ss_i;
  logic [7:0] rd_i [2];
  assign start_i = {start & sel, start & ~sel};

  spi_config_master #(.CLK_DIV(2)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_i[0]), .instr(instr), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_data_req(wreq_i[0]), .rd_data(rd_i[0]), .rd_valid(rdv_i[0]),
    .busy(busy_i[0]), .done(done_i[0]), .sclk(sclk_i[0]), .mosi(mosi_i[0]), .ss(ss_i[0]), .miso(miso));
  spi_config_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_i[1]), .instr(instr), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_data_req(wreq_i[1]), .rd_data(rd_i[1]), .rd_valid(rdv_i[1]),
    .busy(busy_i[1]), .done(done_i[1]), .sclk(sclk_i[1]), .mosi(mosi_i[1]), .ss(ss_i[1]), .miso(miso));

  logic       m_wreq, m_rdv, m_busy, m_done, m_sclk, m_mosi, m_ss;
  logic [7:0] m_rd;
  assign m_wreq = wreq_i[sel];
  assign m_rdv  = rdv_i[sel];
  assign m_busy = busy_i[sel];
  assign m_done = done_i[sel];
  assign m_sclk = sclk_i[sel];
  assign m_mosi = mosi_i[sel];
  assign m_ss   = ss_i[sel];
  assign m_rd   = rd_i[sel];

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_mosi_q[$], wr_src_q[$], miso_q[$], exp_rd_q[$];
  int done_cnt, done_at, wreq_cnt, rdv_cnt, rise_cnt;
  int slv_bit = 0;
  logic [7:0] slv_cur = '0, mosi_sh = '0;
  logic p_sclk = 1'b0, p_ss = 1'b1;

  // slave model and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_done) begin done_cnt++; done_at = cyc - t0; end
      if (m_wreq) begin
        wreq_cnt++;
        if (wr_src_q.size() == 0) check("wr_req_unexpected", 1, 0);
        else wr_data = wr_src_q.pop_front();
      end
      if (m_rdv) begin
        rdv_cnt++;
        if (exp_rd_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rd_data", m_rd, exp_rd_q.pop_front());
      end
      if (p_ss && !m_ss) begin
        slv_bit = 0;
        slv_cur = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        miso = slv_cur[7];
      end
      if (!m_ss && !p_sclk && m_sclk) begin
        rise_cnt++;
        mosi_sh = {mosi_sh[6:0], m_mosi};
        if (slv_bit == 7) begin
          if (exp_mosi_q.size() == 0) check("mosi_extra_byte", 1, 0);
          else check("mosi_byte", mosi_sh, exp_mosi_q.pop_front());
        end
      end
      if (!m_ss && p_sclk && !m_sclk) begin
        if (slv_bit == 7) begin
          slv_bit = 0;
          slv_cur = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        end else slv_bit++;
        miso = slv_cur[7 - slv_bit];
      end
    end
    p_sclk = m_sclk;
    p_ss   = m_ss;
  end

  typedef struct {
    bit          sel;
    logic [7:0]  instr;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  wr0, rd0, rd1;
    bit          inject;
    int          exp_done, exp_end;
  } vec_t;
  vec_t vecs[5];

  task automatic prep(input vec_t v);
    logic [7:0] b;
    exp_mosi_q.delete(); wr_src_q.delete(); miso_q.delete(); exp_rd_q.delete();
    done_cnt = 0; wreq_cnt = 0; rdv_cnt = 0; rise_cnt = 0;
    exp_mosi_q.push_back(v.instr);
    exp_mosi_q.push_back(v.addr[15:8]);
    exp_mosi_q.push_back(v.addr[7:0]);
    for (int k = 0; k < 3; k++) miso_q.push_back(8'($urandom));
    for (int k = 0; k < int'(v.len); k++) begin
      b = (k == 0) ? v.wr0 : 8'($urandom);
      exp_mosi_q.push_back(b);
      wr_src_q.push_back(b);
      b = (k == 0) ? v.rd0 : (k == 1) ? v.rd1 : 8'($urandom);
      miso_q.push_back(b);
      exp_rd_q.push_back(b);
    end
    sel = v.sel;
    @(negedge clk);
    instr = v.instr; addr = v.addr; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("busy_after_start", m_busy, 1);
  endtask

  task automatic run_frame(input vec_t v);
    int n, d, extra;
    prep(v);
    if (v.inject) begin
      repeat (40) @(negedge clk);
      instr = ~v.instr; addr = ~v.addr; len = ~v.len; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (m_busy && n < 20000) begin @(negedge clk); n++; end
    check("frame_timeout", int'(n < 20000), 1);
    d = v.sel ? 1 : 2;
    extra = 0;
`ifdef SPI_CONFIG_MASTER_BYTE_GAP_EN
    extra = (2 + int'(v.len)) * (8 + d);
`endif
    check("idle_cycle", cyc - t0, v.exp_end + extra);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, v.exp_done + extra);
    check("wr_req_count", wreq_cnt, int'(v.len));
    check("rd_valid_count", rdv_cnt, int'(v.len));
    check("sclk_rises", rise_cnt, 8 * (3 + int'(v.len)));
    check("mosi_bytes_left", exp_mosi_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("idle_pins", {m_ss, m_sclk, m_mosi}, 3'b100);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h01, 16'h0003, 8'd1,   8'h5A, 8'h96, 8'h00, 1'b0, 132,  134};
    vecs[1] = '{1'b0, 8'h0B, 16'h0040, 8'd2,   8'h77, 8'hC3, 8'h3C, 1'b0, 164,  166};
    vecs[2] = '{1'b0, 8'hA5, 16'h1234, 8'd0,   8'h00, 8'h00, 8'h00, 1'b0, 100,  102};
    vecs[3] = '{1'b0, 8'h02, 16'h0100, 8'd3,   8'hE1, 8'h11, 8'h22, 1'b1, 196,  198};
    vecs[4] = '{1'b1, 8'h02, 16'h0000, 8'd255, 8'h81, 8'h5A, 8'hA5, 1'b0, 4130, 4131};

    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++)
      check("reset_state", {ss_i[u], sclk_i[u], mosi_i[u], busy_i[u], done_i[u], rdv_i[u], wreq_i[u], rd_i[u]},
            {7'b1000000, 8'h00});
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // abort during the second byte, then a clean frame
    prep(vecs[0]);
    repeat (45) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("reset_abort_pins", {m_ss, m_sclk, m_busy}, 3'b100);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_no_done", done_cnt, 0);
    repeat (2) @(negedge clk);
    run_frame(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
